echo_receive_capture: RTL and testbench
=======================================

// Module: echo_receive_capture
// PURPOSE
//  Receive-side counterpart of the transducer pulse output. It is armed with a receive delay and a sample
//  count, and started by the same 2-bit cmd bus that fires the transmit pulse. After the delay it writes
//  ADC samples into an on-chip buffer, then flags the data ready for host readback.
//  Includes a stall timeout and a sticky error flag.
// PARAMETERS
//  ADC_WIDTH     12  width of one ADC sample
//  ADDR_WIDTH    10  buffer address width; DEPTH = 2**ADDR_WIDTH samples
//  TIMEOUT_BITS  18  width of the watchdog counter; trips at 2**TIMEOUT_BITS-1 cycles
// PORTS
//  clk          in   1             system clock; all logic on posedge
//  reset_n      in   1             asynchronous, active-low reset
//  cmd          in   2             00 idle, 01 load_config, 10 capture, 11 reset_module
//  rcvConfig    in   32            [15:0] rd = receive delay in cycles; [31:16] sc = sample count
//  adcData      in   ADC_WIDTH     ADC sample
//  adcValid     in   1             adcData is valid this cycle
//  rdAddr       in   ADDR_WIDTH    readback address
//  rdData       out  ADC_WIDTH     buffer word at rdAddr, registered, 1-cycle latency
//  isActive     out  1             high in DELAY and CAPTURE
//  dataReady    out  1             capture completed normally
//  sampleCount  out  ADDR_WIDTH+1  samples written in the current/last capture
//  errorFlag    out  1             sticky error
// BEHAVIOUR
//  - Reset (reset_n low, or cmd 11 for one cycle): all outputs 0; rd, sc, counters cleared; state IDLE.
//    Buffer contents are not cleared.
//  - States: IDLE, DELAY, CAPTURE, DONE.
//  - cmd 01 load_config, when not isActive: latch rd and sc.
//    - sc > DEPTH: latch DEPTH and set errorFlag.
//    - While isActive: config ignored, errorFlag set, capture continues.
//  - cmd 10, first cycle T (state IDLE or DONE): dataReady<=0, sampleCount<=0, cnt<=0, wd<=0.
//    - If sc==0: go to DONE with dataReady<=1 at T+1; no buffer writes.
//    - Otherwise go to DELAY.
//  - DELAY: if cnt==rd go to CAPTURE and clear wrAddr; else cnt<=cnt+1.
//    - First sample accepted at T+rd+2; rd=0 gives T+2.
//  - CAPTURE: each cycle with adcValid=1: buf[wrAddr]<=adcData; wrAddr and sampleCount increment.
//    - On the write where wrAddr==sc-1: go to DONE, dataReady<=1, isActive<=0 the next cycle.
//  - DONE with cmd still 10: hold; no re-trigger until cmd leaves 10 and returns.
//  - Watchdog: wd counts every cycle in DELAY or CAPTURE.
//    - At all-ones: set errorFlag, go to IDLE, isActive<=0, dataReady stays 0.
//    - This covers a stalled adcValid or a delay beyond the budget.
//  - cmd leaves 10 during DELAY or CAPTURE (abort): go to IDLE; isActive<=0; dataReady stays 0.
//    sampleCount keeps the partial count. errorFlag is not set.
//  - cmd 00: DONE goes to IDLE. dataReady, sampleCount and the buffer are retained for readback.
//    errorFlag is not cleared; only cmd 11 or reset_n clears it.
//  - Readback: legal at any time. Same-address read during a write returns the old data.
//  - errorFlag: set by the sc clamp, a config load while active, or a watchdog trip.
//    Stays set until cmd 11 or reset_n.
//  - Undefined cmd encodings: none exist; 2-bit decode is complete.
// TESTING
//  1. rd=5, sc=4, cmd=10, adcValid always 1, data 1,2,3,...
//     -> samples 1..4 captured (first at T+7); dataReady=1; sampleCount=4; rdData(addr 2)=3 one cycle after rdAddr=2.
//  2. rd=0, sc=0, cmd=10 -> dataReady=1 at T+1; isActive never high; sampleCount=0.
//  3. sc=3, adcValid toggling 1,0,1,0,...
//     -> only valid samples written at addresses 0..2; dataReady after the 3rd valid sample.
//  4. sc=8, adcValid held 0 -> watchdog trips at 2**18-1 cycles: errorFlag=1, isActive=0, dataReady=0;
//     cmd 00 leaves errorFlag=1; cmd 11 clears it.
//  5. cmd=01 while isActive -> errorFlag=1, rd/sc unchanged, capture completes normally.
//     Separately, sc=2000 loaded -> sc=1024 and errorFlag=1.
//  6. reset_n low mid-CAPTURE -> all outputs 0 immediately.
//     A following capture with sc=2 overwrites only addresses 0..1.

Source files
------------

// File: rtl/echo_receive_capture_if.sv
// echo_receive_capture_if: command, ADC and readback signals of the echo receive capture block
interface echo_receive_capture_if #(
    parameter int ADC_WIDTH  = 12,
    parameter int ADDR_WIDTH = 10
);
    logic [1:0]            cmd;
    logic [31:0]           rcv_config;
    logic [ADC_WIDTH-1:0]  adc_data;
    logic                  adc_valid;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADC_WIDTH-1:0]  rd_data;
    logic                  is_active;
    logic                  data_ready;
    logic [ADDR_WIDTH:0]   sample_count;
    logic                  error_flag;

    modport master (
        output cmd, rcv_config, adc_data, adc_valid, rd_addr,
        input  rd_data, is_active, data_ready, sample_count, error_flag
    );

    modport slave (
        input  cmd, rcv_config, adc_data, adc_valid, rd_addr,
        output rd_data, is_active, data_ready, sample_count, error_flag
    );
endinterface

// File: rtl/echo_receive_capture.sv
// echo_receive_capture: delayed ADC capture into an on-chip buffer with watchdog and sticky error
module echo_receive_capture #(
    parameter int ADC_WIDTH    = 12,
    parameter int ADDR_WIDTH   = 10,
    parameter int TIMEOUT_BITS = 18
) (
    input  logic                   clk,
    input  logic                   reset_n,
    echo_receive_capture_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]     SC_MAX   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]     SC_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0]   ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [TIMEOUT_BITS-1:0] WD_ONE   = TIMEOUT_BITS'(1);
    localparam logic [15:0]             CNT_ONE  = 16'd1;
    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_CAP  = 2'b10;
    localparam logic [1:0] CMD_RST  = 2'b11;

    typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, DONE} state_t;

    state_t                  r_state, w_next;
    logic [15:0]             r_rd, r_cnt;
    logic [ADDR_WIDTH:0]     r_sc, r_sample_count;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [TIMEOUT_BITS-1:0] r_wd;
    logic [1:0]              r_cmd_prev;
    logic                    r_data_ready, r_error;
    logic [ADC_WIDTH-1:0]    r_rd_data;
    logic [ADC_WIDTH-1:0]    r_mem [DEPTH];

    logic        w_active, w_soft_rst, w_start, w_abort, w_wd_trip;
    logic        w_delay_done, w_write, w_last, w_load, w_clamp;
    logic [15:0] w_sc_in;

    assign w_active     = (r_state == DELAY) || (r_state == CAPTURE);
    assign w_soft_rst   = bus.cmd == CMD_RST;
    // capture starts only on the cycle cmd enters 10, so a held 10 never re-triggers
    assign w_start      = (bus.cmd == CMD_CAP) && (r_cmd_prev != CMD_CAP) && !w_active;
    // only cmd 00 aborts; cmd 01 while active is a rejected config load and capture continues
    assign w_abort      = w_active && (bus.cmd == CMD_IDLE);
    assign w_wd_trip    = w_active && (&r_wd);
    assign w_delay_done = (r_state == DELAY) && (r_cnt == r_rd);
    assign w_write      = (r_state == CAPTURE) && bus.adc_valid && !w_soft_rst && !w_abort && !w_wd_trip;
    assign w_last       = w_write && ({1'b0, r_wr_addr} == r_sc - SC_ONE);
    assign w_load       = bus.cmd == CMD_LOAD;
    assign w_sc_in      = bus.rcv_config[31:16];
    assign w_clamp      = w_sc_in > 16'(DEPTH);

    assign bus.is_active    = w_active;
    assign bus.data_ready   = r_data_ready;
    assign bus.sample_count = r_sample_count;
    assign bus.error_flag   = r_error;
    assign bus.rd_data      = r_rd_data;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // next-state decode: soft reset, start, abort/watchdog, then normal progress
    always_comb begin
        w_next = r_state;
        if (w_soft_rst)                                 w_next = IDLE;
        else if (w_start)                               w_next = (r_sc == '0) ? DONE : DELAY;
        else if (w_abort || w_wd_trip)                  w_next = IDLE;
        else if (w_delay_done)                          w_next = CAPTURE;
        else if (w_last)                                w_next = DONE;
        else if (r_state == DONE && bus.cmd == CMD_IDLE) w_next = IDLE;
    end

    // config, counters, watchdog and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || w_soft_rst) begin
            r_rd           <= '0;
            r_sc           <= '0;
            r_cnt          <= '0;
            r_wd           <= '0;
            r_wr_addr      <= '0;
            r_sample_count <= '0;
            r_cmd_prev     <= CMD_IDLE;
            r_data_ready   <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_cmd_prev <= bus.cmd;
            if (w_load && !w_active) begin
                r_rd <= bus.rcv_config[15:0];
                r_sc <= w_clamp ? SC_MAX : w_sc_in[ADDR_WIDTH:0];
            end
            if ((w_load && (w_active || w_clamp)) || (w_wd_trip && !w_abort)) r_error <= 1'b1;
            if (w_start) begin
                r_data_ready   <= r_sc == '0;
                r_sample_count <= '0;
                r_cnt          <= '0;
                r_wd           <= '0;
            end
            if (w_active) r_wd <= r_wd + WD_ONE;
            if (r_state == DELAY && !w_delay_done) r_cnt <= r_cnt + CNT_ONE;
            if (w_delay_done) r_wr_addr <= '0;
            if (w_write) begin
                r_wr_addr      <= r_wr_addr + ADDR_ONE;
                r_sample_count <= r_sample_count + SC_ONE;
            end
            if (w_last) r_data_ready <= 1'b1;
        end
    end

    // sample buffer write port; contents survive every kind of reset
    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wr_addr] <= bus.adc_data;
    end

    // registered readback; a same-address write in this cycle is not yet visible
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        r_rd_data <= '0;
        else if (w_soft_rst) r_rd_data <= '0;
        else                 r_rd_data <= r_mem[bus.rd_addr];
    end
endmodule

// File: tb/tb_echo_receive_capture.sv
// tb_echo_receive_capture: randomized capture scenarios checked against a cycle-level behavioural model
module tb_echo_receive_capture;
    localparam int AW = 10, DW = 12, TW = 12;
    localparam int DEPTH = 2 ** AW;
    localparam int WD_CYCLES = 2 ** TW;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    echo_receive_capture_if #(.ADC_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
    echo_receive_capture #(.ADC_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_BITS(TW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int checks = 0, failures = 0;
    int m_rd = 0, m_sc = 0, m_count = 0;
    bit m_err = 0, m_ready = 0, m_active = 0;
    logic [DW-1:0] m_buf [DEPTH];
    bit m_vld [DEPTH];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_rd = 0; m_sc = 0; m_count = 0; m_err = 0; m_ready = 0; m_active = 0;
    endtask

    task automatic load_cfg(input int rd, input int sc);
        bus.cmd = 2'b01;
        bus.rcv_config = {sc[15:0], rd[15:0]};
        tick();
        m_rd = rd;
        m_sc = (sc > DEPTH) ? DEPTH : sc;
        if (sc > DEPTH) m_err = 1;
        checks++;
        if (bus.error_flag !== m_err) begin
            failures++;
            $display("FAIL load_err sc=%0d got=%0b exp=%0b", sc, bus.error_flag, m_err);
        end
        bus.cmd = 2'b00;
        tick();
    endtask

    // drives one capture; vmode 0 = always valid with data 1,2,3..; 1 = toggling; 2 = random; 3 = never valid
    task automatic run_capture(input int stop_k, input int inj_k, input int vmode);
        int acc = 0;
        int cap0 = m_rd + 2;
        bit v, old_known;
        logic [DW-1:0] d, old;
        bus.cmd = 2'b10;
        bus.adc_valid = 1'b0;
        tick();
        m_count = 0; m_ready = (m_sc == 0); m_active = (m_sc != 0);
        checks++;
        if (bus.is_active !== m_active || bus.data_ready !== m_ready || bus.sample_count !== 11'(m_count)) begin
            failures++;
            $display("FAIL cap_start got=%0b/%0b/%0d exp=%0b/%0b/%0d", bus.is_active, bus.data_ready,
                     bus.sample_count, m_active, m_ready, m_count);
        end
        for (int k = 1; k <= WD_CYCLES + 4 && m_active && k != stop_k; k++) begin
            v = 0;
            d = DW'($urandom);
            if (k >= cap0) begin
                if (vmode == 0) begin v = 1; d = DW'(k - cap0 + 1); end
                else if (vmode == 1) v = ((k - cap0) % 2) == 0;
                else if (vmode == 2) v = 1'($urandom_range(0, 1));
            end
            bus.adc_valid = v;
            bus.adc_data = d;
            bus.cmd = (k == inj_k) ? 2'b01 : 2'b10;
            bus.rcv_config = $urandom;
            bus.rd_addr = AW'(acc);
            old = m_buf[acc];
            old_known = m_vld[acc];
            tick();
            if (k == inj_k) m_err = 1;
            if (k == WD_CYCLES) begin
                m_active = 0; m_err = 1;
            end else if (v && k >= cap0) begin
                m_buf[acc] = d; m_vld[acc] = 1; acc++; m_count = acc;
                if (acc == m_sc) begin m_active = 0; m_ready = 1; end
            end
            checks++;
            if (bus.is_active !== m_active) begin
                failures++;
                $display("FAIL cap_active k=%0d got=%0b exp=%0b", k, bus.is_active, m_active);
            end
            checks++;
            if (bus.data_ready !== m_ready) begin
                failures++;
                $display("FAIL cap_ready k=%0d got=%0b exp=%0b", k, bus.data_ready, m_ready);
            end
            checks++;
            if (bus.sample_count !== 11'(m_count)) begin
                failures++;
                $display("FAIL cap_count k=%0d got=%0d exp=%0d", k, bus.sample_count, m_count);
            end
            checks++;
            if (bus.error_flag !== m_err) begin
                failures++;
                $display("FAIL cap_err k=%0d got=%0b exp=%0b", k, bus.error_flag, m_err);
            end
            if (old_known) begin
                checks++;
                if (bus.rd_data !== old) begin
                    failures++;
                    $display("FAIL cap_read_old k=%0d got=%0h exp=%0h", k, bus.rd_data, old);
                end
            end
        end
        bus.adc_valid = 1'b0;
    endtask

    task automatic readback(input int n);
        for (int a = 0; a < n; a++) begin
            if (m_vld[a]) begin
                bus.rd_addr = AW'(a);
                tick();
                checks++;
                if (bus.rd_data !== m_buf[a]) begin
                    failures++;
                    $display("FAIL readback addr=%0d got=%0h exp=%0h", a, bus.rd_data, m_buf[a]);
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.cmd = 2'b00; bus.rcv_config = '0; bus.adc_data = '0; bus.adc_valid = 1'b0; bus.rd_addr = '0;
        for (int a = 0; a < DEPTH; a++) m_vld[a] = 0;
        #2 reset_n = 1'b0;
        #10;
        checks++;
        if ({bus.is_active, bus.data_ready, bus.error_flag} !== 3'b000 || bus.sample_count !== '0 || bus.rd_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0b%0b%0b/%0d/%0h exp=000/0/0", bus.is_active, bus.data_ready,
                     bus.error_flag, bus.sample_count, bus.rd_data);
        end
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        model_clear();
    endtask

    task automatic test_basic();
        load_cfg(5, 4);
        run_capture(0, -1, 0);
        checks++;
        if (bus.sample_count !== 11'd4 || bus.data_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_done got=%0d/%0b exp=4/1", bus.sample_count, bus.data_ready);
        end
        readback(4);
        bus.rd_addr = 10'd2;
        tick();
        checks++;
        if (bus.rd_data !== 12'd3) begin
            failures++;
            $display("FAIL basic_addr2 got=%0h exp=3", bus.rd_data);
        end
    endtask

    task automatic test_zero();
        bus.cmd = 2'b00;
        tick();
        load_cfg(0, 0);
        run_capture(0, -1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.is_active !== 1'b0 || bus.data_ready !== 1'b1 || bus.sample_count !== '0) begin
                failures++;
                $display("FAIL zero_hold i=%0d got=%0b/%0b/%0d exp=0/1/0", i, bus.is_active, bus.data_ready,
                         bus.sample_count);
            end
        end
    endtask

    task automatic test_toggle();
        load_cfg($urandom_range(0, 6), 3);
        run_capture(0, -1, 1);
        readback(3);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            load_cfg($urandom_range(0, 30), $urandom_range(1, 40));
            run_capture(0, -1, 2);
            for (int i = 0; i < 2; i++) begin
                tick();
                checks++;
                if (bus.is_active !== 1'b0 || bus.data_ready !== 1'b1 || bus.sample_count !== 11'(m_count)) begin
                    failures++;
                    $display("FAIL b2b_hold r=%0d got=%0b/%0b/%0d exp=0/1/%0d", r, bus.is_active, bus.data_ready,
                             bus.sample_count, m_count);
                end
            end
            readback(m_sc);
            bus.cmd = 2'b00;
            tick();
            checks++;
            if (bus.data_ready !== 1'b1 || bus.sample_count !== 11'(m_count)) begin
                failures++;
                $display("FAIL b2b_retain r=%0d got=%0b/%0d exp=1/%0d", r, bus.data_ready, bus.sample_count, m_count);
            end
            run_capture(0, -1, 2);
            bus.cmd = 2'b00;
            tick();
        end
    endtask

    task automatic test_load_active();
        load_cfg(3, 6);
        run_capture(0, 2, 2);
        readback(6);
        bus.cmd = 2'b00;
        tick();
    endtask

    task automatic test_clamp();
        bus.cmd = 2'b11;
        tick();
        model_clear();
        checks++;
        if (bus.error_flag !== 1'b0 || bus.data_ready !== 1'b0 || bus.sample_count !== '0) begin
            failures++;
            $display("FAIL softrst got=%0b/%0b/%0d exp=0/0/0", bus.error_flag, bus.data_ready, bus.sample_count);
        end
        bus.cmd = 2'b00;
        tick();
        load_cfg(0, 2000);
        run_capture(0, -1, 0);
        checks++;
        if (bus.sample_count !== 11'd1024 || bus.error_flag !== 1'b1) begin
            failures++;
            $display("FAIL clamp_done got=%0d/%0b exp=1024/1", bus.sample_count, bus.error_flag);
        end
        readback(8);
        bus.cmd = 2'b00;
        tick();
    endtask

    task automatic test_abort();
        load_cfg(2, 20);
        run_capture(10, -1, 0);
        bus.cmd = 2'b00;
        tick();
        m_ready = 0;
        checks++;
        if (bus.is_active !== 1'b0 || bus.data_ready !== 1'b0 || bus.sample_count !== 11'd6 || bus.error_flag !== m_err) begin
            failures++;
            $display("FAIL abort got=%0b/%0b/%0d/%0b exp=0/0/6/%0b", bus.is_active, bus.data_ready,
                     bus.sample_count, bus.error_flag, m_err);
        end
    endtask

    task automatic test_watchdog();
        load_cfg(0, 8);
        run_capture(0, -1, 3);
        bus.cmd = 2'b00;
        tick();
        checks++;
        if (bus.error_flag !== 1'b1 || bus.is_active !== 1'b0 || bus.data_ready !== 1'b0) begin
            failures++;
            $display("FAIL wd_idle got=%0b/%0b/%0b exp=1/0/0", bus.error_flag, bus.is_active, bus.data_ready);
        end
        bus.cmd = 2'b11;
        tick();
        model_clear();
        checks++;
        if (bus.error_flag !== 1'b0) begin
            failures++;
            $display("FAIL wd_clear got=%0b exp=0", bus.error_flag);
        end
        bus.cmd = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        load_cfg(1, 10);
        run_capture(5, -1, 0);
        #3 reset_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({bus.is_active, bus.data_ready, bus.error_flag} !== 3'b000 || bus.sample_count !== '0 || bus.rd_data !== '0) begin
            failures++;
            $display("FAIL mid_reset got=%0b%0b%0b/%0d/%0h exp=000/0/0", bus.is_active, bus.data_ready,
                     bus.error_flag, bus.sample_count, bus.rd_data);
        end
        bus.cmd = 2'b00;
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        load_cfg($urandom_range(0, 5), 2);
        run_capture(0, -1, 2);
        readback(16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_toggle();
        test_back_to_back();
        test_load_active();
        test_clamp();
        test_abort();
        test_watchdog();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
